// File: rtl/dram_fifo_reader_if.sv
// Read-side stream and RAM-port bundle for dram_fifo_reader.
// level_o exists only when DRAM_FIFO_READER_LEVEL_EN is defined.
interface dram_fifo_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4
);
    logic [DATA_DEPTH:0]   wptr;
    logic [DATA_DEPTH-1:0] ar;
    logic [DATA_WIDTH-1:0] qr;
    logic [DATA_DEPTH:0]   rptr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  flush;
    logic                  ovf;
`ifdef DRAM_FIFO_READER_LEVEL_EN
    logic [DATA_DEPTH:0]   level_o;
`endif

    // Reader side: consumes wptr/qr, produces the stream and pointer
    modport slave (
        input  wptr,
        input  qr,
        input  out_ready,
        input  flush,
        output ar,
        output rptr,
        output out_data,
        output out_valid,
`ifdef DRAM_FIFO_READER_LEVEL_EN
        output level_o,
`endif
        output ovf
    );

    // Environment side: writer, RAM and consumer
    modport master (
        output wptr,
        output qr,
        output out_ready,
        output flush,
        input  ar,
        input  rptr,
        input  out_data,
        input  out_valid,
`ifdef DRAM_FIFO_READER_LEVEL_EN
        input  level_o,
`endif
        input  ovf
    );
endinterface

// File: rtl/dram_fifo_reader.sv
// Read controller for a distributed-RAM FIFO: drives the RAM read address,
// registers one word into a valid/ready stage. Optional macro DRAM_FIFO_READER_LEVEL_EN.
module dram_fifo_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    dram_fifo_reader_if.slave bus
);
    localparam logic [DATA_DEPTH:0] FULL_LEVEL = {1'b1, {DATA_DEPTH{1'b0}}};
    localparam logic [DATA_DEPTH:0] PTR_ONE    = {{DATA_DEPTH{1'b0}}, 1'b1};

    logic [DATA_DEPTH:0]   rptr_r;
    logic [DATA_DEPTH:0]   rptr_next_s;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [DATA_WIDTH-1:0] out_data_next_s;
    logic                  out_valid_r;
    logic                  out_valid_next_s;
    logic                  ovf_r;
    logic                  ovf_next_s;
    logic                  empty_s;
    logic                  load_s;
    logic                  overrun_s;
    logic [DATA_DEPTH:0]   level_s;

    // Occupancy decode; the wrap bit makes empty and full distinguishable
    always_comb begin
        empty_s   = (bus.wptr == rptr_r);
        level_s   = bus.wptr - rptr_r;
        overrun_s = (level_s > FULL_LEVEL);
        load_s    = !empty_s && (!out_valid_r || bus.out_ready);
    end

    // Next-state for pointer and output stage, flush outranks everything
    always_comb begin
        rptr_next_s      = rptr_r;
        out_data_next_s  = out_data_r;
        out_valid_next_s = out_valid_r;
        if (bus.flush) begin
            rptr_next_s      = bus.wptr;
            out_valid_next_s = 1'b0;
        end else if (load_s) begin
            rptr_next_s      = rptr_r + PTR_ONE;
            out_data_next_s  = bus.qr;
            out_valid_next_s = 1'b1;
        end else if (out_valid_r && bus.out_ready && empty_s) begin
            out_valid_next_s = 1'b0;
        end else begin
            rptr_next_s      = rptr_r;
            out_valid_next_s = out_valid_r;
        end
    end

    // Sticky overrun flag, cleared only by flush or reset
    always_comb begin
        ovf_next_s = ovf_r;
        if (bus.flush) begin
            ovf_next_s = 1'b0;
        end else if (overrun_s) begin
            ovf_next_s = 1'b1;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_r      <= {(DATA_DEPTH+1){1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            rptr_r      <= rptr_next_s;
            out_data_r  <= out_data_next_s;
            out_valid_r <= out_valid_next_s;
            ovf_r       <= ovf_next_s;
        end
    end

`ifdef DRAM_FIFO_READER_LEVEL_EN
    logic [DATA_DEPTH:0] level_r;
    logic [DATA_DEPTH:0] level_next_s;

    // RAM-resident word count as it will stand after this edge
    always_comb begin
        level_next_s = {(DATA_DEPTH+1){1'b0}};
        if (bus.flush) begin
            level_next_s = {(DATA_DEPTH+1){1'b0}};
        end else begin
            level_next_s = bus.wptr - rptr_next_s;
        end
    end

    // Level register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= {(DATA_DEPTH+1){1'b0}};
        end else begin
            level_r <= level_next_s;
        end
    end

    assign bus.level_o = level_r;
`endif

    // Read address follows the pointer so qr is valid in the same cycle
    assign bus.ar        = rptr_r[DATA_DEPTH-1:0];
    assign bus.rptr      = rptr_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_dram_fifo_reader.sv
// Directed bench for dram_fifo_reader: behavioural writer + async-read RAM,
// hand-computed expectations and a queue scoreboard for the random-ready burst.
module tb_dram_fifo_reader;
    logic clk;
    logic rst_n;
    logic [15:0] ram [16];
    int n_checks;
    int n_pass;
    logic [15:0] exp_q [$];
    logic [15:0] wdata;
    int written;
    int accepted;

    dram_fifo_reader_if #(.DATA_WIDTH(16), .DATA_DEPTH(4)) bus ();

    dram_fifo_reader #(.DATA_WIDTH(16), .DATA_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.qr = ram[bus.ar];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] d);
        ram[bus.wptr[3:0]] = d;
        bus.wptr = bus.wptr + 5'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.wptr      = 5'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 16; i++) ram[i] = 16'h0000;
        rst_n         = 1'b0;
        bus.wptr      = 5'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();

        check_value("rst_valid", 32'(bus.out_valid), 32'd0);
        check_value("rst_rptr",  32'(bus.rptr),      32'd0);
        check_value("rst_ar",    32'(bus.ar),        32'd0);
        check_value("rst_ovf",   32'(bus.ovf),       32'd0);
        check_value("rst_data",  32'(bus.out_data),  32'd0);

        // Three back-to-back words with the consumer always ready
        bus.out_ready = 1'b1;
        write_word(16'h1111);
        check_value("lat_pre", 32'(bus.out_valid), 32'd0);
        step();
        check_value("seq_v0", 32'(bus.out_valid), 32'd1);
        check_value("seq_d0", 32'(bus.out_data),  32'h1111);
        write_word(16'h2222);
        step();
        check_value("seq_d1", 32'(bus.out_data), 32'h2222);
        write_word(16'h3333);
        step();
        check_value("seq_d2", 32'(bus.out_data), 32'h3333);
        check_value("seq_rptr", 32'(bus.rptr), 32'd3);
        step();
        check_value("seq_drain", 32'(bus.out_valid), 32'd0);
        check_value("seq_rptr_end", 32'(bus.rptr), 32'd3);

        // Fill to full under backpressure, then drain
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_word(16'(16'hA000 + i));
            step();
        end
        check_value("bp_rptr", 32'(bus.rptr),      32'd1);
        check_value("bp_data", 32'(bus.out_data),  32'hA000);
        check_value("bp_vld",  32'(bus.out_valid), 32'd1);
        step();
        check_value("bp_hold_rptr", 32'(bus.rptr),     32'd1);
        check_value("bp_hold_data", 32'(bus.out_data), 32'hA000);
        check_value("bp_ovf", 32'(bus.ovf), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_value("drain_vld",  32'(bus.out_valid), 32'd1);
            check_value("drain_data", 32'(bus.out_data),  32'(16'hA000 + i));
            step();
        end
        check_value("drain_end_vld", 32'(bus.out_valid), 32'd0);
        check_value("drain_rptr",    32'(bus.rptr),      32'h10);
        check_value("drain_ar",      32'(bus.ar),        32'd0);

        // Asynchronous reset while a word is held
        bus.out_ready = 1'b0;
        write_word(16'hBEEF);
        step();
        check_value("pre_arst_vld", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n    = 1'b0;
        bus.wptr = 5'd0;
        #1;
        check_value("arst_vld",  32'(bus.out_valid), 32'd0);
        check_value("arst_rptr", 32'(bus.rptr),      32'd0);
        check_value("arst_data", 32'(bus.out_data),  32'd0);
        #1;
        rst_n = 1'b1;
        step();

        // 40 words with random consumer readiness, at most 16 outstanding
        written  = 0;
        accepted = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 2000 && accepted < 40; cyc++) begin
            if (written < 40 && (written - accepted) < 16 && $urandom_range(0, 3) != 0) begin
                wdata = 16'(16'h5A00 + written);
                write_word(wdata);
                exp_q.push_back(wdata);
                written++;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                check_value("burst_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                accepted++;
            end
            step();
        end
        check_value("burst_count", 32'(accepted), 32'd40);
        check_value("burst_rptr",  32'(bus.rptr), 32'd8);
        check_value("burst_vld",   32'(bus.out_valid), 32'd0);
        check_value("burst_ovf",   32'(bus.ovf), 32'd0);

        // Overrun: rptr=8, force wptr 17 ahead
        bus.out_ready = 1'b0;
        bus.wptr      = 5'd25;
        step();
        check_value("ovf_set",  32'(bus.ovf),  32'd1);
        check_value("ovf_rptr", 32'(bus.rptr), 32'd9);
        step();
        check_value("ovf_hold", 32'(bus.ovf), 32'd1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check_value("flush_rptr", 32'(bus.rptr),      32'd25);
        check_value("flush_vld",  32'(bus.out_valid), 32'd0);
        check_value("flush_ovf",  32'(bus.ovf),       32'd0);
        step();
        check_value("post_flush_vld", 32'(bus.out_valid), 32'd0);
        check_value("post_flush_ovf", 32'(bus.ovf),       32'd0);

`ifdef DRAM_FIFO_READER_LEVEL_EN
        do_reset();
        check_value("lvl_rst", 32'(bus.level_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            write_word(16'(16'hC000 + i));
            step();
        end
        step();
        check_value("lvl_four", 32'(bus.level_o), 32'd4);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check_value("lvl_flush", 32'(bus.level_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dram_fifo_reader.md
Name: dram_fifo_reader

Overview:
- Read-side controller for a single-clock FIFO stored in a 2^DATA_DEPTH-entry distributed RAM with an asynchronous read port.
- The write-side logic owns the RAM write port and the write pointer.
- This block owns the read address and the read pointer, and presents the data as a registered valid/ready stream.
- It returns its read pointer to the writer for full detection, and flags overrun.

Parameters:
DATA_WIDTH, 16, width of RAM word and output data
DATA_DEPTH, 4, log2 of RAM entries; pointers are DATA_DEPTH+1 bits (MSB = wrap bit)

Ports:
clk  input  1  single clock; all state changes on posedge
rst_n  input  1  asynchronous active-low reset
wptr  input  DATA_DEPTH+1  writer's registered write pointer; the word at wptr-1 is valid in RAM in the same cycle wptr is seen
ar  output  DATA_DEPTH  RAM read address, equal to rptr[DATA_DEPTH-1:0] (combinational)
qr  input  DATA_WIDTH  RAM asynchronous read data for address ar
rptr  output  DATA_DEPTH+1  read pointer, returned to writer
out_data  output  DATA_WIDTH  registered output word
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data when out_valid&out_ready at posedge
flush  input  1  synchronous discard of all buffered words
ovf  output  1  sticky overrun flag

Behaviour:
- Reset (rst_n=0, asynchronous): rptr=0, out_data=0, out_valid=0, ovf=0. Reset mid-operation discards the output word. The writer is reset by the same rst_n, so wptr is also 0.
- empty = (wptr == rptr), full MSB-inclusive compare.
- level = wptr - rptr, modulo 2^(DATA_DEPTH+1).
- ar = rptr[DATA_DEPTH-1:0] at all times; qr is sampled the same cycle.
- load = !empty && (!out_valid || out_ready).
- Priority per posedge, highest first:
  1. flush: rptr <= wptr, out_valid <= 0, ovf <= 0. out_data is unchanged, and an out_ready in the same cycle has no effect.
  2. load: out_data <= qr, out_valid <= 1, rptr <= rptr+1 (wraps modulo 2^(DATA_DEPTH+1)).
  3. out_valid && out_ready && empty: out_valid <= 0.
  4. Otherwise hold.
- Throughput: 1 word/clk when the FIFO is non-empty and out_ready=1 continuously.
- Latency: word written at edge N (wptr increments at N) → out_valid=1 after edge N+1.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_valid and rptr hold; no RAM read is consumed.
- Wrap-around: the rptr MSB toggles each 2^DATA_DEPTH reads; ar wraps 15→0 (default).
- Overrun: if level > 2^DATA_DEPTH at any posedge, ovf <= 1 and stays set until flush or reset. Data read after an overrun is undefined. rptr is not corrected.
- Full (level == 2^DATA_DEPTH) is legal; the writer must block on it.
- Simultaneous write and read on the same edge are independent: rptr advances, and wptr advances in the writer.
- No combinational path from out_ready to out_valid or out_data; rptr depends only on registers.

Optional Feature:
- Macro DRAM_FIFO_READER_LEVEL_EN.
- Defined: adds output port level_o, width DATA_DEPTH+1, registered. Each posedge it takes wptr_next_seen - rptr_next, i.e. it equals (wptr - rptr) one cycle later. Reset value 0; set to 0 on flush. Counts only words still in RAM, excluding the out_data holding register.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then wptr=0 → out_valid=0, rptr=0, ar=0, ovf=0. Assert rst_n=0 mid-stream with out_valid=1 → out_valid=0 immediately, without waiting for clk.
- Writer stores 0x1111,0x2222,0x3333 on consecutive edges, out_ready=1 → out_valid rises one edge after the first write. out_data sequence 0x1111,0x2222,0x3333 on consecutive cycles, then out_valid=0; rptr=3.
- Fill 16 words with out_ready=0 → only the first word loads (rptr=1, out_data=word0), then everything holds. Raise out_ready → 16 words in order, one per clk; rptr=16 (MSB set, ar=0).
- Write 40 words in bursts with random out_ready, never exceeding 16 outstanding → output order preserved across two pointer wraps; ovf stays 0.
- Force wptr=rptr+17 → ovf=1 after the next edge, holds. Pulse flush → rptr=wptr, out_valid=0, ovf=0 next edge.
- With DRAM_FIFO_READER_LEVEL_EN: 5 words written, out_ready=0 → level_o settles to 4 (one word in out_data). Flush → level_o=0.
